// File: rtl/cache_types.sv
// Shared types for the cache hierarchy.
//   arb_state_t - pmem arbiter grant state
//   arb_side_t  - which requester holds or last held the pmem grant
//   LINE_W      - cache line / pmem data width in bits
//   pick_side   - priority picker used by the arbiter when leaving IDLE
package cache_types;

   localparam int unsigned LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D
   } arb_state_t;

   typedef enum logic {
      SIDE_I,
      SIDE_D
   } arb_side_t;

   // Only meaningful when at least one request is present. Under contention the
   // data side wins unless alternation is enabled, in which case the side that
   // did not hold the previous grant wins.
   function automatic arb_side_t pick_side(input logic      i_req,
                                           input logic      d_req,
                                           input logic      round_robin,
                                           input arb_side_t last);
      arb_side_t side;
      if (!d_req) begin
         side = SIDE_I;
      end else if (!i_req) begin
         side = SIDE_D;
      end else if (round_robin) begin
         side = (last == SIDE_D) ? SIDE_I : SIDE_D;
      end else begin
         side = SIDE_D;
      end
      return side;
   endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical-memory line port between the instruction
// cache (I side, reads only) and the data cache (D side, reads and write-backs).
// One requester is granted at a time; the grant is held until pmem completes,
// then the arbiter spends one cycle in IDLE before sampling requests again.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_read, i_address        I-side line read request and address
//   i_rdata, i_resp          I-side line data and one-cycle completion pulse
//   d_read, d_write          D-side line read / write-back requests
//   d_address, d_wdata       D-side address and write-back line
//   d_rdata, d_resp          D-side line data and one-cycle completion pulse
//   pmem_read, pmem_write    physical memory command
//   pmem_address, pmem_wdata physical address and write data
//   pmem_rdata               physical read data
//   pmem_resp, pmem_error    physical completion; error completes like resp
module pmem_arbiter #(
   parameter int unsigned LINE_W      = cache_types::LINE_W,
   parameter int unsigned ROUND_ROBIN = 0
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_read,
   input  logic [31:0]       i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   input  logic              pmem_error
);

   import cache_types::*;

   arb_state_t state;
   arb_side_t  last_grant;

   logic d_req;
   logic done;
   logic rr_en;

   assign d_req = d_read | d_write;
   assign done  = pmem_resp | pmem_error;
   assign rr_en = (ROUND_ROBIN != 0);

   // Requests are only looked at in IDLE, so a request raised mid-grant waits
   // and a request dropped in the cycle after resp is never re-granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= SIDE_I;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_read | d_req) begin
                  if (pick_side(i_read, d_req, rr_en, last_grant) == SIDE_D) begin
                     state      <= GRANT_D;
                     last_grant <= SIDE_D;
                  end else begin
                     state      <= GRANT_I;
                     last_grant <= SIDE_I;
                  end
               end
            end
            GRANT_I, GRANT_D: begin
               if (done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Command mux: driven from the registered state so requests only reach pmem
   // through the address/data selection, never through the grant decision.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      unique case (state)
         GRANT_I: begin
            pmem_read    = 1'b1;
            pmem_address = i_address;
         end
         GRANT_D: begin
            // A simultaneous read and write from the D side resolves to the write.
            pmem_read    = d_read & ~d_write;
            pmem_write   = d_write;
            pmem_address = d_address;
            pmem_wdata   = d_wdata;
         end
         default: ;
      endcase
   end

   assign i_resp  = (state == GRANT_I) & done;
   assign d_resp  = (state == GRANT_D) & done;
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

`ifndef SYNTHESIS
   a_d_rw_conflict : assert property (@(posedge clk) disable iff (rst)
      (state == GRANT_D) |-> !(d_read && d_write))
      else $error("pmem_arbiter: d_read and d_write both asserted");

   a_i_drop : assert property (@(posedge clk) disable iff (rst)
      ((state == GRANT_I) && !done) |-> i_read)
      else $error("pmem_arbiter: i_read dropped during grant");

   a_d_drop : assert property (@(posedge clk) disable iff (rst)
      ((state == GRANT_D) && !done) |-> d_req)
      else $error("pmem_arbiter: d request dropped during grant");

   a_idle_resp : assert property (@(posedge clk) disable iff (rst)
      (state == IDLE) |-> !done)
      else $error("pmem_arbiter: pmem completion while idle");
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read, d_read, d_write;
   logic [31:0]   i_address, d_address;
   logic [LW-1:0] d_wdata, pmem_rdata;
   logic          pmem_resp, pmem_error;

   // fixed-priority instance
   logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
   logic          i_resp, d_resp, pmem_read, pmem_write;
   logic [31:0]   pmem_address;
   // round-robin instance
   logic [LW-1:0] r_i_rdata, r_d_rdata, r_pmem_wdata;
   logic          r_i_resp, r_d_resp, r_pmem_read, r_pmem_write;
   logic [31:0]   r_pmem_address;

   int total = 0;
   int bad   = 0;
   int txn_cnt = 0;

   always #5 clk = ~clk;

   pmem_arbiter #(.LINE_W(LW), .ROUND_ROBIN(0)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .pmem_error(pmem_error)
   );

   pmem_arbiter #(.LINE_W(LW), .ROUND_ROBIN(1)) dut_rr (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(r_i_rdata), .i_resp(r_i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(r_d_rdata), .d_resp(r_d_resp),
      .pmem_read(r_pmem_read), .pmem_write(r_pmem_write), .pmem_address(r_pmem_address),
      .pmem_wdata(r_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .pmem_error(pmem_error)
   );

   // completed pmem transactions on the fixed-priority instance
   always @(posedge clk)
      if (!rst && (pmem_read || pmem_write) && (pmem_resp || pmem_error)) txn_cnt++;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #3;
   endtask

   task automatic test_reset;
      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0;
      i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
      pmem_resp = 0; pmem_error = 0;
      cyc(); cyc(); settle();
      total++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
         bad++; $display("FAIL reset_ctl: got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp});
      end
      total++;
      if (pmem_address !== 32'h0 || pmem_wdata !== '0) begin
         bad++; $display("FAIL reset_addr: got %h want 0", pmem_address);
      end
      cyc(); rst = 1'b0; settle();
   endtask

   task automatic test_single_i;
      logic [LW-1:0] a5;
      a5 = {32{8'hA5}};
      cyc(); i_read = 1; i_address = 32'h60; settle();
      total++;
      if (pmem_read !== 1'b0) begin
         bad++; $display("FAIL i_latency: pmem_read got %b want 0", pmem_read);
      end
      for (int k = 1; k <= 4; k++) begin
         cyc();
         if (k == 4) begin pmem_resp = 1; pmem_rdata = a5; end
         settle();
         total++;
         if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h60
             || pmem_wdata !== '0) begin
            bad++; $display("FAIL i_cmd c%0d: rd=%b wr=%b addr=%h want rd=1 wr=0 addr=60",
                            k, pmem_read, pmem_write, pmem_address);
         end
         total++;
         if (i_resp !== (k == 4) || d_resp !== 1'b0) begin
            bad++; $display("FAIL i_resp c%0d: i_resp=%b d_resp=%b want %b 0", k, i_resp, d_resp, k == 4);
         end
      end
      total++;
      if (i_rdata !== a5) begin
         bad++; $display("FAIL i_rdata: got %h want %h", i_rdata, a5);
      end
      cyc(); pmem_resp = 0; i_read = 0; settle();
      total++;
      if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
         bad++; $display("FAIL i_done: rd=%b i_resp=%b want 0 0", pmem_read, i_resp);
      end
   endtask

   task automatic test_single_d_write;
      logic [LW-1:0] w;
      w = {8{32'h1234_5678}};
      cyc(); d_write = 1; d_address = 32'h1FE0; d_wdata = w; settle();
      cyc(); settle();
      total++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h1FE0
          || pmem_wdata !== w) begin
         bad++; $display("FAIL d_cmd: wr=%b rd=%b addr=%h want 1 0 1fe0", pmem_write, pmem_read,
                         pmem_address);
      end
      cyc(); settle();
      total++;
      if (d_resp !== 1'b0) begin
         bad++; $display("FAIL d_early_resp: got %b want 0", d_resp);
      end
      cyc(); pmem_resp = 1; settle();
      total++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
         bad++; $display("FAIL d_resp: d=%b i=%b want 1 0", d_resp, i_resp);
      end
      cyc(); pmem_resp = 0; d_write = 0; settle();
      total++;
      if (pmem_write !== 1'b0 || d_resp !== 1'b0) begin
         bad++; $display("FAIL d_done: wr=%b d_resp=%b want 0 0", pmem_write, d_resp);
      end
   endtask

   // Last grant is D here, so the round-robin instance picks I on contention.
   task automatic test_contention;
      logic [LW-1:0] r1;
      r1 = {8{32'hC0DE_0001}};
      cyc(); txn_cnt = 0; i_read = 1; i_address = 32'h200;
      d_read = 1; d_address = 32'h100; settle();
      cyc(); settle();
      total++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h100) begin
         bad++; $display("FAIL fp_first: rd=%b addr=%h want 1 100", pmem_read, pmem_address);
      end
      total++;
      if (r_pmem_read !== 1'b1 || r_pmem_address !== 32'h200) begin
         bad++; $display("FAIL rr_pick_i: rd=%b addr=%h want 1 200", r_pmem_read, r_pmem_address);
      end
      cyc(); pmem_resp = 1; pmem_rdata = r1; settle();
      total++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== r1) begin
         bad++; $display("FAIL fp_route: d=%b i=%b want 1 0", d_resp, i_resp);
      end
      total++;
      if (r_i_resp !== 1'b1 || r_d_resp !== 1'b0) begin
         bad++; $display("FAIL rr_route: d=%b i=%b want 0 1", r_d_resp, r_i_resp);
      end
      cyc(); pmem_resp = 0; d_read = 0; settle();
      total++;
      if (pmem_read !== 1'b0) begin
         bad++; $display("FAIL fp_gap: rd=%b want 0", pmem_read);
      end
      cyc(); settle();
      total++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h200) begin
         bad++; $display("FAIL fp_second: rd=%b addr=%h want 1 200", pmem_read, pmem_address);
      end
      cyc(); pmem_resp = 1; settle();
      total++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
         bad++; $display("FAIL fp_second_resp: i=%b d=%b want 1 0", i_resp, d_resp);
      end
      cyc(); pmem_resp = 0; i_read = 0; settle();
      total++;
      if (txn_cnt !== 2 || pmem_read !== 1'b0) begin
         bad++; $display("FAIL txn_count: got %0d rd=%b want 2 0", txn_cnt, pmem_read);
      end
   endtask

   task automatic test_back_to_back;
      logic          exp_d [4];
      logic [31:0]   exp_a;
      logic [LW-1:0] rd;
      exp_d[0] = 1; exp_d[1] = 0; exp_d[2] = 1; exp_d[3] = 0;
      cyc(); i_read = 1; d_read = 1; settle();
      for (int t = 0; t < 4; t++) begin
         cyc();
         if (t > 0) begin
            if (exp_d[t-1]) d_read = 1; else i_read = 1;
         end
         rd = {8{32'hBEEF_0000 + 32'(t)}};
         pmem_resp = 1; pmem_rdata = rd; settle();
         exp_a = exp_d[t] ? 32'h100 : 32'h200;
         total++;
         if (pmem_address !== exp_a || d_resp !== exp_d[t] || i_resp !== !exp_d[t]) begin
            bad++; $display("FAIL b2b_fp t%0d: addr=%h d=%b i=%b want %h %b %b", t, pmem_address,
                            d_resp, i_resp, exp_a, exp_d[t], !exp_d[t]);
         end
         total++;
         if (r_pmem_address !== exp_a || r_d_resp !== exp_d[t] || r_i_resp !== !exp_d[t]) begin
            bad++; $display("FAIL b2b_rr t%0d: addr=%h d=%b i=%b want %h %b %b", t, r_pmem_address,
                            r_d_resp, r_i_resp, exp_a, exp_d[t], !exp_d[t]);
         end
         cyc(); pmem_resp = 0;
         if (exp_d[t]) d_read = 0; else i_read = 0;
         if (t == 3) begin d_read = 0; i_read = 0; end
         settle();
         total++;
         if (pmem_read !== 1'b0 || r_pmem_read !== 1'b0) begin
            bad++; $display("FAIL b2b_gap t%0d: rd=%b rr_rd=%b want 0 0", t, pmem_read, r_pmem_read);
         end
      end
   endtask

   task automatic test_reset_mid_grant;
      cyc(); i_read = 1; i_address = 32'h300; settle();
      cyc(); settle();
      cyc(); rst = 1; i_read = 0; settle();
      total++;
      if (pmem_read !== 1'b1) begin
         bad++; $display("FAIL rst_pre: rd=%b want 1", pmem_read);
      end
      cyc(); rst = 0; settle();
      total++;
      if (pmem_read !== 1'b0 || i_resp !== 1'b0 || pmem_address !== 32'h0 || r_pmem_read !== 1'b0) begin
         bad++; $display("FAIL rst_idle: rd=%b i_resp=%b addr=%h want 0 0 0", pmem_read, i_resp,
                         pmem_address);
      end
      cyc(); i_read = 1; i_address = 32'h340; settle();
      cyc(); pmem_resp = 1; pmem_rdata = {8{32'h0340_0340}}; settle();
      total++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h340 || i_resp !== 1'b1) begin
         bad++; $display("FAIL rst_regrant: rd=%b addr=%h i_resp=%b want 1 340 1", pmem_read,
                         pmem_address, i_resp);
      end
      cyc(); pmem_resp = 0; i_read = 0; settle();
   endtask

   task automatic test_error;
      cyc(); d_read = 1; d_address = 32'h400; settle();
      cyc(); i_read = 1; i_address = 32'h480; settle();
      total++;
      if (pmem_address !== 32'h400 || pmem_read !== 1'b1) begin
         bad++; $display("FAIL err_grant: addr=%h rd=%b want 400 1", pmem_address, pmem_read);
      end
      cyc(); pmem_error = 1; settle();
      total++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
         bad++; $display("FAIL err_resp: d=%b i=%b want 1 0", d_resp, i_resp);
      end
      cyc(); pmem_error = 0; d_read = 0; settle();
      total++;
      if (pmem_read !== 1'b0 || d_resp !== 1'b0) begin
         bad++; $display("FAIL err_idle: rd=%b d=%b want 0 0", pmem_read, d_resp);
      end
      cyc(); settle();
      total++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h480 || r_pmem_address !== 32'h480) begin
         bad++; $display("FAIL err_next_i: rd=%b addr=%h rr_addr=%h want 1 480 480", pmem_read,
                         pmem_address, r_pmem_address);
      end
      cyc(); pmem_resp = 1; settle();
      total++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
         bad++; $display("FAIL err_i_resp: i=%b d=%b want 1 0", i_resp, d_resp);
      end
      cyc(); pmem_resp = 0; i_read = 0; settle();
   endtask

   initial begin
      test_reset();
      test_single_i();
      test_single_d_write();
      test_contention();
      test_back_to_back();
      test_reset_mid_grant();
      test_error();
      cyc(); cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, want finish before 100000");
      $fatal(1);
   end

endmodule
